// File: rtl/guess_round_if.sv
// Handshake/scoring bundle between the round sequencer and the
// entry/display side of the LED guessing game.
interface guess_round_if;
    logic        start;
    logic        submit;
    logic [11:0] guess_code;
    logic        guess_enable;
    logic [2:0]  exact_cnt;
    logic [7:0]  hint;
    logic [3:0]  tries_used;
    logic        win;
    logic        lose;
    logic        blink_phase;
    logic [11:0] secret_out;

    modport master (
        output start, submit, guess_code,
        input  guess_enable, exact_cnt, hint, tries_used,
        input  win, lose, blink_phase, secret_out
    );

    modport slave (
        input  start, submit, guess_code,
        output guess_enable, exact_cnt, hint, tries_used,
        output win, lose, blink_phase, secret_out
    );
endinterface

// File: rtl/guess_round_ctrl.sv
// Round sequencer: LFSR secret, guess scoring, win/lose, blink phase.
// Optional GUESS_REVEAL_EN exposes the secret while in LOSE.
module guess_round_ctrl #(
    parameter int          MAX_TRIES = 8,
    parameter int          BLINK_DIV = 25000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst_n,
    guess_round_if.slave  bus
);
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_PLAY, S_CHECK, S_WIN, S_LOSE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [15:0]   r_lfsr;
    logic [11:0]   r_secret;
    logic [11:0]   r_guess_q;
    logic [2:0]    r_exact;
    logic [7:0]    r_hint;
    logic [3:0]    r_tries;
    logic          r_en;
    logic          r_win;
    logic          r_lose;
    logic          r_blink;
    logic [CW-1:0] r_bcnt;
    logic [2:0]    w_exact;
    logic [7:0]    w_hint;
    logic [3:0]    w_tries_inc;
    logic          w_fb;
    logic          w_idle_like;

    assign w_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
    assign w_tries_inc = r_tries + 4'd1;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_WIN) ||
                         (r_state == S_LOSE);

    always_comb begin
        w_exact = '0;
        w_hint  = '0;
        for (int i = 0; i < 4; i++) begin
            if (r_guess_q[3*i +: 3] == r_secret[3*i +: 3])
                w_exact = w_exact + 3'd1;
            else if (r_guess_q[3*i +: 3] < r_secret[3*i +: 3])
                w_hint[2*i +: 2] = 2'b01;
            else
                w_hint[2*i +: 2] = 2'b10;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_WIN, S_LOSE:
                if (bus.start) w_next = S_PLAY;
            S_PLAY:
                if (bus.submit) w_next = S_CHECK;
            S_CHECK:
                if (w_exact == 3'd4)
                    w_next = S_WIN;
                else if (w_tries_inc == 4'(MAX_TRIES))
                    w_next = S_LOSE;
                else
                    w_next = S_PLAY;
            default:
                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // State flags are registered from the next state so they line up
    // with the score update on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr    <= LFSR_SEED;
            r_secret  <= '0;
            r_guess_q <= '0;
            r_exact   <= '0;
            r_hint    <= '0;
            r_tries   <= '0;
            r_en      <= 1'b0;
            r_win     <= 1'b0;
            r_lose    <= 1'b0;
        end else begin
            r_lfsr <= {r_lfsr[14:0], w_fb};
            r_en   <= (w_next == S_PLAY);
            r_win  <= (w_next == S_WIN);
            r_lose <= (w_next == S_LOSE);
            if (w_idle_like && bus.start) begin
                r_secret <= r_lfsr[11:0];
                r_tries  <= '0;
                r_exact  <= '0;
                r_hint   <= '0;
            end
            if (r_state == S_PLAY && bus.submit)
                r_guess_q <= bus.guess_code;
            if (r_state == S_CHECK) begin
                r_exact <= w_exact;
                r_hint  <= w_hint;
                r_tries <= w_tries_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bcnt  <= '0;
            r_blink <= 1'b0;
        end else if (r_bcnt == CW'(BLINK_DIV - 1)) begin
            r_bcnt  <= '0;
            r_blink <= ~r_blink;
        end else begin
            r_bcnt <= r_bcnt + CW'(1);
        end
    end

`ifdef GUESS_REVEAL_EN
    logic [11:0] r_secret_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_secret_out <= '0;
        else        r_secret_out <= (w_next == S_LOSE) ? r_secret : '0;
    end

    assign bus.secret_out = r_secret_out;
`else
    assign bus.secret_out = '0;
`endif

    assign bus.guess_enable = r_en;
    assign bus.exact_cnt    = r_exact;
    assign bus.hint         = r_hint;
    assign bus.tries_used   = r_tries;
    assign bus.win          = r_win;
    assign bus.lose         = r_lose;
    assign bus.blink_phase  = r_blink;
endmodule

// File: tb/tb_guess_round_ctrl.sv
// Randomized bench for guess_round_ctrl against a round-level model.
// Directed scenarios first, then random start/submit/reset traffic.
module tb_guess_round_ctrl;
    localparam int MAXT = 8;
    localparam int BDIV = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    guess_round_if bus();

    guess_round_ctrl #(
        .MAX_TRIES(MAXT),
        .BLINK_DIV(BDIV),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Round-level model: a round is live from start until won/lost,
    // with at most one guess waiting to be scored.
    logic [15:0] m_lfsr;
    logic [11:0] m_secret, m_gq;
    int          m_tries, m_exact, m_bcnt;
    logic [7:0]  m_hint;
    bit          m_live, m_pending, m_won, m_lost, m_blink;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    task automatic m_reset();
        m_lfsr = 16'hACE1; m_secret = '0; m_gq = '0;
        m_tries = 0; m_exact = 0; m_hint = '0; m_bcnt = 0;
        m_live = 0; m_pending = 0; m_won = 0; m_lost = 0; m_blink = 0;
    endtask

    task automatic m_step(input bit st, input bit sb, input logic [11:0] g);
        logic [15:0] old;
        int gd, sd;
        old = m_lfsr;
        m_lfsr = lfsr_step(old);
        m_bcnt++;
        if (m_bcnt == BDIV) begin
            m_bcnt = 0;
            m_blink = !m_blink;
        end
        if (m_pending) begin
            m_pending = 0;
            m_exact = 0;
            m_hint = '0;
            for (int d = 0; d < 4; d++) begin
                gd = int'((m_gq >> (3 * d)) & 12'h7);
                sd = int'((m_secret >> (3 * d)) & 12'h7);
                if (gd == sd) m_exact++;
                else if (gd < sd) m_hint = m_hint | (8'h1 << (2 * d));
                else m_hint = m_hint | (8'h2 << (2 * d));
            end
            m_tries++;
            if (m_exact == 4) m_won = 1;
            else if (m_tries == MAXT) m_lost = 1;
            if (m_won || m_lost) m_live = 0;
        end else if (m_live) begin
            if (sb) begin
                m_gq = g;
                m_pending = 1;
            end
        end else if (st) begin
            m_secret = old[11:0];
            m_tries = 0; m_exact = 0; m_hint = '0;
            m_live = 1; m_won = 0; m_lost = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [11:0] exp_so;
`ifdef GUESS_REVEAL_EN
        exp_so = m_lost ? m_secret : 12'h0;
`else
        exp_so = 12'h0;
`endif
        chk({tag, ".en"}, 32'(bus.guess_enable), 32'(m_live && !m_pending));
        chk({tag, ".exact"}, 32'(bus.exact_cnt), 32'(m_exact));
        chk({tag, ".hint"}, 32'(bus.hint), 32'(m_hint));
        chk({tag, ".tries"}, 32'(bus.tries_used), 32'(m_tries));
        chk({tag, ".win"}, 32'(bus.win), 32'(m_won));
        chk({tag, ".lose"}, 32'(bus.lose), 32'(m_lost));
        chk({tag, ".blink"}, 32'(bus.blink_phase), 32'(m_blink));
        chk({tag, ".sout"}, 32'(bus.secret_out), 32'(exp_so));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.submit = 1'b0;
        m_reset();
        #1 check_all("rst");
        repeat (3) @(posedge clk);
        #1 check_all("rst_hold");
    endtask

    task automatic cyc(input bit st, input bit sb, input logic [11:0] g);
        @(negedge clk);
        rst_n = 1'b1;
        bus.start = st;
        bus.submit = sb;
        bus.guess_code = g;
        m_step(st, sb, g);
        @(posedge clk);
        #1 check_all("cyc");
    endtask

    task automatic guess(input logic [11:0] g);
        cyc(1'b0, 1'b1, g);
        cyc(1'b0, 1'b0, 12'h0);
    endtask

    initial begin
        logic [11:0] exp_reveal;
        int r;
        bit st, sb;
        logic [11:0] g;
`ifdef GUESS_REVEAL_EN
        exp_reveal = 12'hCE1;
`else
        exp_reveal = 12'h0;
`endif
        bus.start = 1'b0;
        bus.submit = 1'b0;
        bus.guess_code = '0;
        m_reset();

        do_reset();
        cyc(1'b1, 1'b0, 12'h0);
        chk("seed.en", 32'(bus.guess_enable), 32'd1);
        chk("seed.tries", 32'(bus.tries_used), 32'd0);

        guess({3'd6, 3'd7, 3'd0, 3'd1});
        chk("part.exact", 32'(bus.exact_cnt), 32'd2);
        chk("part.hint", 32'(bus.hint), 32'b00_10_01_00);
        chk("part.tries", 32'(bus.tries_used), 32'd1);
        chk("part.en", 32'(bus.guess_enable), 32'd1);

        repeat (6) guess(12'h000);
        guess({3'd6, 3'd3, 3'd4, 3'd1});
        chk("final.win", 32'(bus.win), 32'd1);
        chk("final.lose", 32'(bus.lose), 32'd0);
        chk("final.exact", 32'(bus.exact_cnt), 32'd4);
        chk("final.hint", 32'(bus.hint), 32'd0);
        chk("final.tries", 32'(bus.tries_used), 32'd8);
        chk("final.en", 32'(bus.guess_enable), 32'd0);
        guess(12'h000);
        chk("won.hold", 32'(bus.exact_cnt), 32'd4);
        cyc(1'b1, 1'b0, 12'h0);
        chk("restart.en", 32'(bus.guess_enable), 32'd1);
        chk("restart.tries", 32'(bus.tries_used), 32'd0);

        do_reset();
        cyc(1'b1, 1'b0, 12'h0);
        repeat (8) guess(12'h000);
        chk("lose.lose", 32'(bus.lose), 32'd1);
        chk("lose.win", 32'(bus.win), 32'd0);
        chk("lose.tries", 32'(bus.tries_used), 32'd8);
        chk("lose.sout", 32'(bus.secret_out), 32'(exp_reveal));

        cyc(1'b1, 1'b0, 12'h0);
        cyc(1'b1, 1'b1, 12'h123);
        chk("both.en", 32'(bus.guess_enable), 32'd0);
        cyc(1'b1, 1'b0, 12'h0);
        chk("both.tries", 32'(bus.tries_used), 32'd1);

        do_reset();
        cyc(1'b0, 1'b1, 12'hCE1);
        chk("idle_sub.en", 32'(bus.guess_enable), 32'd0);
        chk("idle_sub.tries", 32'(bus.tries_used), 32'd0);

        cyc(1'b1, 1'b0, 12'h0);
        cyc(1'b0, 1'b1, 12'h0);
        do_reset();
        chk("midchk.tries", 32'(bus.tries_used), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            if (r < 2) begin
                do_reset();
            end else begin
                st = ($urandom_range(0, 7) == 0);
                sb = ($urandom_range(0, 2) == 0);
                g = ($urandom_range(0, 3) == 0) ? m_secret
                                                : 12'($urandom);
                cyc(st, sb, g);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/guess_round_ctrl.md
Name: guess_round_ctrl

Overview:
- Round sequencer for the 4-digit LED guessing game.
- Generates a secret 4-digit code (3 bits per digit) from a free-running LFSR.
- Gates the guess entry module through its enable input and scores each submitted guess.
- Tracks attempts and declares win or lose. Also supplies the cursor blink phase to the entry/display logic.

Parameters:
- MAX_TRIES, 8, number of guesses allowed per round (1..15).
- BLINK_DIV, 25000000, clk cycles per blink_phase half-period (>=2).
- LFSR_SEED, 16'hACE1, LFSR reset value (must be nonzero).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level, sampled each edge; begins a new round when accepted.
- submit  in  1  single-cycle pulse (debounced upstream); scores the current guess.
- guess_code  in  12  current entry digits: [2:0]=digit0 (led_zero) ... [11:9]=digit3 (led_three).
- guess_enable  out  1  drives the entry module's enable.
- exact_cnt  out  3  digits matching in position on the last scored guess (0..4).
- hint  out  8  per-digit hint, 2 bits each, [1:0]=digit0: 00 equal, 01 guess low, 10 guess high.
- tries_used  out  4  guesses scored this round.
- win  out  1  high in WIN state.
- lose  out  1  high in LOSE state.
- blink_phase  out  1  square wave for the selected-digit blink.
- secret_out  out  12  see Optional Feature.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, lfsr=LFSR_SEED, secret=0, exact_cnt=0, hint=0, tries_used=0.
  - guess_enable=0, win=0, lose=0, blink_phase=0, blink counter=0.
  - All outputs are registered.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11.
  - Advances every clk cycle in every state.
- States: IDLE, PLAY, CHECK, WIN, LOSE.
- IDLE/WIN/LOSE with start=1 at an edge:
  - secret <= lfsr[11:0], using the pre-advance value on that edge.
  - tries_used <= 0, exact_cnt <= 0, hint <= 0, state <= PLAY.
- PLAY:
  - guess_enable=1.
  - submit=1: state <= CHECK and guess_code is latched into guess_q.
  - start is ignored in PLAY.
  - If start and submit arrive together, submit is taken.
- CHECK (exactly 1 cycle):
  - guess_enable=0.
  - exact_cnt <= count of guess_q digit i == secret digit i.
  - hint[2i+1:2i] <= 00/01/10 from an unsigned 3-bit compare.
  - tries_used <= tries_used+1.
- CHECK exit:
  - Next state is WIN if the computed exact count equals 4.
  - Else LOSE if tries_used+1 == MAX_TRIES.
  - Else PLAY.
  - WIN takes priority over LOSE on the final try.
- Latency: submit edge to updated scores and tries_used is 2 edges; win/lose are valid on the same edge as the score.
- Outputs by state:
  - WIN: win=1, guess_enable=0, scores hold.
  - LOSE: lose=1, guess_enable=0, scores hold.
  - win and lose are never both 1.
- Any submit outside PLAY is ignored.
- blink_phase:
  - Counter counts 0..BLINK_DIV-1; blink_phase toggles on wrap.
  - Runs in all states.
- Reset mid-round: returns to IDLE immediately, with no partial score update.

Optional Feature:
- Macro: GUESS_REVEAL_EN.
- Defined: secret_out = secret in the LOSE state only, 0 otherwise (registered, updates on LOSE entry).
- Undefined: secret_out is constant 0 and no extra registers are inferred.
- Scoring behaviour is identical either way.

Test Plan:
- Reset then seed capture: rst_n low for 3 cycles, release, start=1 on the first edge.
  - Required: state PLAY, guess_enable=1, tries_used=0.
  - Required: secret digits d0=1, d1=4, d2=3, d3=6 (secret=12'hCE1), checked with GUESS_REVEAL_EN after forced loss.
- Partial guess: guess_code digits (1,0,7,6), submit pulse.
  - 2 edges later: exact_cnt=2, hint=8'b00_10_01_00, tries_used=1, back in PLAY.
- Win: guess_code = secret (d0=1, d1=4, d2=3, d3=6), submit.
  - Required: exact_cnt=4, hint=0, win=1, guess_enable=0.
  - A further submit changes nothing.
  - start=1 then gives PLAY, tries_used=0.
- Lose and final-try priority: MAX_TRIES=8.
  - 8 wrong submits: lose=1 after the 8th, tries_used=8, secret_out=12'hCE1 (REVEAL on), 0 (REVEAL off).
  - Repeat with 7 wrong then a correct guess: win=1, lose=0.
- Simultaneous and illegal events:
  - start+submit together in PLAY: CHECK is taken and the round is not restarted.
  - submit in IDLE: ignored.
  - rst_n low during CHECK: IDLE, all outputs 0.
- Blink: BLINK_DIV=4.
  - Required: blink_phase toggles every 4 edges from reset, independent of state.
